// File: rtl/shift_right_seq.sv
// Multi-cycle SRL/SRA unit that resolves one barrel stage per cycle, MSB stage first.
// Define SHIFT_STICKY_EN to build the shifted-out sticky accumulator and the data_sticky port.
module shift_right_seq #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_start,
    input  logic               ctrl_arith,
    input  logic [WIDTH-1:0]   data_operandA,
    input  logic [SHAMT_W-1:0] ctrl_shiftamt,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
`ifdef SHIFT_STICKY_EN
    ,output logic              data_sticky
`endif
);

    localparam int CNT_W = $clog2(SHAMT_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic               arith_q, arith_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [CNT_W-1:0]   stageIdx;
    logic [SHAMT_W-1:0] stepAmt;
    logic [WIDTH-1:0]   fillMask;
    logic [WIDTH-1:0]   stageOut;
    logic [WIDTH-1:0]   workNext;
    logic               stageTaken;
    logic               stageDropped;
    logic               lastStage;

`ifdef SHIFT_STICKY_EN
    logic stickyAcc_q, stickyAcc_d;
    logic sticky_q, sticky_d;
`endif

    // Counter value i selects shamt bit SHAMT_W-1-i, i.e. a step of 2^(SHAMT_W-1-i).
    always_comb begin
        stageIdx     = CNT_W'(SHAMT_W - 1) - cnt_q;
        stepAmt      = SHAMT_W'(1) << stageIdx;
        fillMask     = ~({WIDTH{1'b1}} >> stepAmt);
        stageOut     = (work_q >> stepAmt) | ((arith_q && sign_q) ? fillMask : '0);
        stageDropped = |(work_q & ~({WIDTH{1'b1}} << stepAmt));
        stageTaken   = shamt_q[stageIdx];
        workNext     = stageTaken ? stageOut : work_q;
        lastStage    = (cnt_q == CNT_W'(SHAMT_W - 1));
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        shamt_d  = shamt_q;
        arith_d  = arith_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
`ifdef SHIFT_STICKY_EN
        stickyAcc_d = stickyAcc_q;
        sticky_d    = sticky_q;
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    state_d = SHIFT;
                    work_d  = data_operandA;
                    shamt_d = ctrl_shiftamt;
                    arith_d = ctrl_arith;
                    sign_d  = data_operandA[WIDTH-1];
                    cnt_d   = '0;
`ifdef SHIFT_STICKY_EN
                    stickyAcc_d = 1'b0;
`endif
                end
            end
            SHIFT: begin
                work_d = workNext;
                cnt_d  = cnt_q + CNT_W'(1);
`ifdef SHIFT_STICKY_EN
                stickyAcc_d = stickyAcc_q | (stageTaken & stageDropped);
`endif
                if (lastStage) begin
                    state_d  = DONE;
                    result_d = workNext;
`ifdef SHIFT_STICKY_EN
                    sticky_d = stickyAcc_q | (stageTaken & stageDropped);
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            work_q   <= '0;
            result_q <= '0;
            shamt_q  <= '0;
            arith_q  <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef SHIFT_STICKY_EN
            stickyAcc_q <= 1'b0;
            sticky_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            shamt_q  <= shamt_d;
            arith_q  <= arith_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
`ifdef SHIFT_STICKY_EN
            stickyAcc_q <= stickyAcc_d;
            sticky_q    <= sticky_d;
`endif
        end
    end

    assign data_result    = result_q;
    assign data_resultRDY = (state_q == DONE);
    assign busy           = (state_q != IDLE);
`ifdef SHIFT_STICKY_EN
    assign data_sticky    = sticky_q;
`endif

`ifndef SHIFT_STICKY_EN
    // Stage drop detection only feeds the optional sticky accumulator.
    logic unusedDropped;
    assign unusedDropped = stageDropped;
`endif

endmodule

// File: tb/tb_shift_right_seq.sv
// Scoreboard bench for shift_right_seq: directed ops push expectations, a monitor checks each RDY.
// Sticky expectations are checked only when SHIFT_STICKY_EN is defined.
module tb_shift_right_seq;

    logic        clock;
    logic        reset;
    logic        ctrl_start;
    logic        ctrl_arith;
    logic [31:0] data_operandA;
    logic [4:0]  ctrl_shiftamt;
    logic [31:0] data_result;
    logic        data_resultRDY;
    logic        busy;
    logic        stickyOut;

    typedef struct {
        logic [31:0] result;
        logic        sticky;
        string       name;
    } expect_t;

    expect_t scoreQ[$];
    int checks = 0;
    int errors = 0;

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_arith     (ctrl_arith),
        .data_operandA  (data_operandA),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_result    (data_result),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
`ifdef SHIFT_STICKY_EN
        ,.data_sticky   (stickyOut)
`endif
    );

`ifndef SHIFT_STICKY_EN
    assign stickyOut = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: pops one expectation per RDY pulse.
    always @(negedge clock) begin
        if (!reset && data_resultRDY === 1'b1) begin
            if (scoreQ.size() == 0) begin
                checkOutput("unexpected_rdy", 32'd1, 32'd0);
            end else begin
                expect_t e;
                e = scoreQ.pop_front();
                checkOutput({e.name, "_result"}, data_result, e.result);
`ifdef SHIFT_STICKY_EN
                checkOutput({e.name, "_sticky"}, {31'd0, stickyOut}, {31'd0, e.sticky});
`endif
            end
        end
    end

    // Issue one op at a negedge (cycle 0) and verify busy/RDY timing for cycles 1..7.
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [4:0] sh,
                                 input logic ar, input logic [31:0] expRes, input logic expSticky);
        expect_t e;
        @(negedge clock);
        data_operandA = a;
        ctrl_shiftamt = sh;
        ctrl_arith    = ar;
        ctrl_start    = 1'b1;
        e.result = expRes;
        e.sticky = expSticky;
        e.name   = name;
        scoreQ.push_back(e);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clock);
            if (c == 1) begin
                ctrl_start    = 1'b0;
                data_operandA = ~a;
                ctrl_shiftamt = ~sh;
                ctrl_arith    = ~ar;
            end
            checkOutput($sformatf("%s_rdy_c%0d", name, c), {31'd0, data_resultRDY}, {31'd0, c == 6});
            checkOutput($sformatf("%s_busy_c%0d", name, c), {31'd0, busy}, {31'd0, c <= 6});
        end
    endtask

    initial begin
        expect_t e;
        reset = 1'b1;
        ctrl_start = 1'b0;
        ctrl_arith = 1'b0;
        data_operandA = '0;
        ctrl_shiftamt = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset_result", data_result, 32'h0);
        checkOutput("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_sticky", {31'd0, stickyOut}, 32'd0);
        reset = 1'b0;

        applyStimulus("srl_msb4",   32'h8000_0000, 5'd4,  1'b0, 32'h0800_0000, 1'b0);
        applyStimulus("sra_msb4",   32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, 1'b0);
        applyStimulus("sra_ones31", 32'hFFFF_FFFF, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("srl_ones31", 32'hFFFF_FFFF, 5'd31, 1'b0, 32'h0000_0001, 1'b1);
        applyStimulus("identity",   32'h1234_5678, 5'd0,  1'b0, 32'h1234_5678, 1'b0);
        applyStimulus("sra_mix8",   32'hF000_000F, 5'd8,  1'b1, 32'hFFF0_0000, 1'b1);
        applyStimulus("srl_mix13",  32'h0F0F_0F0F, 5'd13, 1'b0, 32'h0000_7878, 1'b1);
        applyStimulus("sra_min31",  32'h8000_0001, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus("sticky_set", 32'h0000_000F, 5'd4,  1'b0, 32'h0000_0000, 1'b1);
        applyStimulus("sticky_clr", 32'h0000_0010, 5'd4,  1'b0, 32'h0000_0001, 1'b0);

        // Starts in cycles 3 and 6 are ignored; the start held into cycle 7 is accepted.
        @(negedge clock);
        data_operandA = 32'h0000_0100;
        ctrl_shiftamt = 5'd8;
        ctrl_arith    = 1'b0;
        ctrl_start    = 1'b1;
        e.result = 32'h0000_0001; e.sticky = 1'b0; e.name = "busy_first";
        scoreQ.push_back(e);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clock);
            ctrl_start = (c == 3 || c == 6 || c == 7);
            if (ctrl_start) begin
                data_operandA = 32'hFFFF_FFFF;
                ctrl_shiftamt = 5'd4;
            end
            if (c == 7) begin
                e.result = 32'h0FFF_FFFF; e.sticky = 1'b1; e.name = "busy_second";
                scoreQ.push_back(e);
            end
            if (c == 9) checkOutput("busy_hold_result", data_result, 32'h0000_0001);
            checkOutput($sformatf("busy_rdy_c%0d", c), {31'd0, data_resultRDY}, {31'd0, c == 6 || c == 13});
            checkOutput($sformatf("busy_busy_c%0d", c), {31'd0, busy}, {31'd0, c <= 6 || (c >= 8 && c <= 13)});
        end

        // Reset in cycle 3 aborts the op without a RDY pulse.
        @(negedge clock);
        data_operandA = 32'hFFFF_FFFF;
        ctrl_shiftamt = 5'd4;
        ctrl_arith    = 1'b1;
        ctrl_start    = 1'b1;
        @(negedge clock);
        ctrl_start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_result", data_result, 32'h0);
        checkOutput("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_sticky", {31'd0, stickyOut}, 32'd0);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clock);
            checkOutput($sformatf("abort_idle_rdy_%0d", c), {31'd0, data_resultRDY}, 32'd0);
        end
        applyStimulus("after_abort", 32'hC000_0000, 5'd2, 1'b1, 32'hF000_0000, 1'b0);

        repeat (2) @(negedge clock);
        checkOutput("scoreboard_empty", scoreQ.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
